multicycle_control: RTL



---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer. Latency: lw 5, sw/R-type 4, beq/bne/j 3 cycles, plus one per mem_ready-low cycle.
// Waits in memory states while mem_ready is low; halts on an illegal opcode or memory timeout until reset.
module multicycle_control #(
  parameter int TIMEOUT  = 16,
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          Op,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchNe,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic [3:0]          state,
  output logic                halted,
  output logic [1:0]          error_code,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t      st;
  logic [CW-1:0] cnt;
  logic [1:0]  err;

  assign state      = st;
  assign halted     = (st == HALT);
  assign error_code = err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= FETCH;
      cnt     <= '0;
      err     <= 2'b00;
      retired <= '0;
    end else begin
      // Counter only survives while a memory state is stalling; any move clears it.
      cnt <= '0;
      case (st)
        FETCH, MEM_READ, MEM_WRITE: begin
          if (mem_ready) begin
            case (st)
              FETCH:    st <= DECODE;
              MEM_READ: st <= MEM_WB;
              default: begin
                st      <= FETCH;
                retired <= retired + RETIRE_W'(1);
              end
            endcase
          end else if (cnt == LAST) begin
            st  <= HALT;
            err <= 2'b10;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DECODE: begin
          case (Op)
            OP_R:          st <= EXECUTE;
            OP_LW, OP_SW:  st <= MEM_ADDR;
            OP_BEQ, OP_BNE: st <= BRANCH;
            OP_J:          st <= JUMP;
            default: begin
              st  <= HALT;
              err <= 2'b01;
            end
          endcase
        end
        MEM_ADDR: st <= (Op == OP_SW) ? MEM_WRITE : MEM_READ;
        EXECUTE:  st <= R_WB;
        MEM_WB, R_WB, BRANCH, JUMP: begin
          st      <= FETCH;
          retired <= retired + RETIRE_W'(1);
        end
        HALT:     st <= HALT;
        default:  st <= FETCH;
      endcase
    end
  end

  // Controls decode straight from state so an asynchronous reset silences them at once.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (!reset) begin
      case (st)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE:   ALUSrcB = 2'b11;
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchNe    = Op[0];
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
